fifo_sync_ctrl: RTL and testbench
=================================

// Module: fifo_sync_ctrl
// PURPOSE
//  Single-clock FIFO controller. Owns write/read pointers, occupancy and status
//  flags, and sequences one FIFO_MEM instance (DEPTH = 2**AW entries).
//  Valid/ready handshake on both sides; first-word-fall-through read.
//  Used wherever a block needs a same-clock elastic buffer.
// PARAMETERS
//  DW         32         data width, passed to FIFO_MEM
//  AW         4          address width; DEPTH = 1<<AW
//  AF_THRESH  (1<<AW)-2  O_ALMOST_FULL asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  1          O_ALMOST_EMPTY asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  I_CLK          in   1     clock; all logic on its rising edge
//  I_RSTN         in   1     asynchronous, active-low reset
//  I_CLR          in   1     synchronous flush, one cycle, active-high
//  I_WR_VALID     in   1     write request
//  O_WR_READY     out  1     space available (= !full)
//  I_WR_DATA      in   DW    write data
//  O_RD_VALID     out  1     data available (= !empty)
//  I_RD_READY     in   1     consumer accepts O_RD_DATA
//  O_RD_DATA      out  DW    head-of-FIFO data, valid while O_RD_VALID
//  O_COUNT        out  AW+1  occupancy, 0..DEPTH
//  O_ALMOST_FULL  out  1     count >= AF_THRESH
//  O_ALMOST_EMPTY out  1     count <= AE_THRESH
//  O_PEAK         out  AW+1  highest count since reset/clear
// BEHAVIOUR
//  - Pointers wptr/rptr are AW+1 bits: bit AW is the wrap bit, [AW-1:0] is the mem address.
//    empty = (wptr == rptr); full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]).
//  - wr_fire = I_WR_VALID & O_WR_READY drives FIFO_MEM I_WR_EN, with I_WR_ADDR = wptr[AW-1:0].
//    wptr increments by 1 on each wr_fire. rd_fire = O_RD_VALID & I_RD_READY increments rptr.
//  - O_RD_DATA is FIFO_MEM O_RD_DATA, addressed combinationally by rptr[AW-1:0].
//    A word written at edge N is visible with O_RD_VALID=1 in cycle N+1 (1-cycle latency).
//  - O_WR_READY and O_RD_VALID are combinational from the pointer registers only.
//    They never depend on I_WR_VALID or I_RD_READY, so no combinational loop is formed.
//  - Full with I_RD_READY=1: O_WR_READY stays 0 that cycle and the write is not accepted
//    (no pass-through). Empty with I_WR_VALID=1: O_RD_VALID stays 0 (no bypass).
//  - Simultaneous wr_fire and rd_fire: both pointers advance and count is unchanged.
//  - Count register: +1 on write only, -1 on read only, unchanged on both or neither.
//    Count never exceeds DEPTH and never underflows, by construction.
//  - Pointer wrap: the low AW bits roll from DEPTH-1 to 0 and the wrap bit toggles.
//  - O_PEAK <= max(O_PEAK, next_count) every cycle.
//  - Almost flags are combinational compares on the registered count.
//  - I_CLR: wptr, rptr, count and O_PEAK go to 0 at the next edge.
//    I_CLR takes priority over any wr_fire/rd_fire in the same cycle; those transfers are
//    discarded (the mem write still happens but is unreachable). Handshakes in the I_CLR
//    cycle still show pre-clear status.
//  - Reset (I_RSTN=0, any time, mid-transfer included): pointers, count and O_PEAK = 0.
//    Outputs during and after reset: O_WR_READY=1, O_RD_VALID=0, O_COUNT=0, O_PEAK=0,
//    O_ALMOST_FULL=0, O_ALMOST_EMPTY=1. Memory contents are not reset; O_RD_DATA is
//    don't-care while O_RD_VALID=0.
//  - Elaboration check: AF_THRESH and AE_THRESH must be in range, else $error.
// STRUCTURE
//  - Shared package fifo_pkg: pointer width function ptr_w(AW) = AW+1, and the
//    ptr_full/ptr_empty compare functions, reused by a later async FIFO.
//  - One sub-module: FIFO_MEM (u_mem), built as the RTL model, not VENDOR_RAM.
//    Everything else is flat in this module.
// TESTING  (DW=8, AW=2, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
//  1 Reset, then write 0xA1,0xA2 (1/cycle), then read 2 -> data A1,A2 in order;
//    COUNT 0,1,2,1,0; O_RD_VALID rises the cycle after the first write.
//  2 Write 5 words back-to-back with I_RD_READY=0 -> 4 accepted; O_WR_READY=0 after the
//    4th; 5th held until one read; COUNT=4, AF=1, PEAK=4.
//  3 Full, then WR_VALID=1 and RD_READY=1 together -> read fires, write is refused that
//    cycle and accepted the next; COUNT 4->3->4.
//  4 Continuous write+read of 0x00..0x0F with depth 4 -> output sequence 0x00..0x0F
//    intact across 4 pointer wraps; COUNT constant once primed.
//  5 COUNT=3, then I_CLR with WR_VALID=1 -> next cycle COUNT=0, PEAK=0, RD_VALID=0,
//    AE=1; the dropped word never appears.
//  6 Assert I_RSTN=0 mid-burst, asynchronously, between edges -> outputs go to reset
//    values immediately; after release, the FIFO behaves as empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width and wrap-bit pointer compares.
package fifo_pkg;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int unsigned ptr_w(input int unsigned aw);
    return aw + 1;
  endfunction

  // Pointers are passed zero-extended to 32 bits; aw selects the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] wptr, input logic [31:0] rptr);
    return wptr == rptr;
  endfunction

  function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                    input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (wptr[aw] != rptr[aw]) && ((wptr & mask) == (rptr & mask));
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, combinational read port, no reset.
module fifo_mem #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          I_CLK,
  input  logic          I_WR_EN,
  input  logic [AW-1:0] I_WR_ADDR,
  input  logic [DW-1:0] I_WR_DATA,
  input  logic [AW-1:0] I_RD_ADDR,
  output logic [DW-1:0] O_RD_DATA
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0] mem_q [Depth];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge I_CLK) begin
    if (I_WR_EN) begin
      mem_q[I_WR_ADDR] <= I_WR_DATA;
    end
  end

  // Read port feeds first-word-fall-through output directly.
  always_comb begin
    O_RD_DATA = mem_q[I_RD_ADDR];
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FWFT FIFO controller: pointers, occupancy, flags and peak tracking.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 4,
  parameter int unsigned AF_THRESH = (1 << AW) - 2,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic          I_CLK,
  input  logic          I_RSTN,
  input  logic          I_CLR,
  input  logic          I_WR_VALID,
  output logic          O_WR_READY,
  input  logic [DW-1:0] I_WR_DATA,
  output logic          O_RD_VALID,
  input  logic          I_RD_READY,
  output logic [DW-1:0] O_RD_DATA,
  output logic [AW:0]   O_COUNT,
  output logic          O_ALMOST_FULL,
  output logic          O_ALMOST_EMPTY,
  output logic [AW:0]   O_PEAK
);

  localparam int unsigned PW    = ptr_w(AW);
  localparam int unsigned Depth = 1 << AW;

  localparam logic [AW:0] AfThresh = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AeThresh = (AW + 1)'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > Depth) begin : g_af_range_err
    $error("fifo_sync_ctrl: AF_THRESH %0d outside 1..%0d", AF_THRESH, Depth);
  end
  if (AE_THRESH > Depth - 1) begin : g_ae_range_err
    $error("fifo_sync_ctrl: AE_THRESH %0d outside 0..%0d", AE_THRESH, Depth - 1);
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   peak_q, peak_d;
  logic          empty, full, wr_fire, rd_fire;

  // Status depends only on pointer registers, keeping handshakes loop-free.
  always_comb begin
    empty          = ptr_empty(32'(wptr_q), 32'(rptr_q));
    full           = ptr_full(32'(wptr_q), 32'(rptr_q), AW);
    O_WR_READY     = ~full;
    O_RD_VALID     = ~empty;
    wr_fire        = I_WR_VALID & ~full;
    rd_fire        = I_RD_READY & ~empty;
    O_COUNT        = count_q;
    O_PEAK         = peak_q;
    O_ALMOST_FULL  = (count_q >= AfThresh);
    O_ALMOST_EMPTY = (count_q <= AeThresh);
  end

  // Next-state; clear overrides any transfer in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    peak_d  = peak_q;
    if (I_CLR) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      peak_d  = '0;
    end else begin
      if (wr_fire) wptr_d = wptr_q + PW'(1);
      if (rd_fire) rptr_d = rptr_q + PW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
      if (count_d > peak_q) peak_d = count_d;
    end
  end

  // State registers.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  // A write in the clear cycle still lands in memory but is unreachable afterwards.
  fifo_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .I_CLK     (I_CLK),
    .I_WR_EN   (wr_fire),
    .I_WR_ADDR (wptr_q[AW-1:0]),
    .I_WR_DATA (I_WR_DATA),
    .I_RD_ADDR (rptr_q[AW-1:0]),
    .O_RD_DATA (O_RD_DATA)
  );

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl against a queue-based reference model.
module tb_fifo_sync_ctrl;

  localparam int Dw = 8;
  localparam int Aw = 2;
  localparam int DepthM = 4;
  localparam int AfT = 3;
  localparam int AeT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [Dw-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [Dw-1:0] rd_data;
  logic [Aw:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic [Aw:0]   peak;

  int checks = 0;
  int errors = 0;

  logic [Dw-1:0] q[$];
  int            peak_m = 0;

  always #5 clk = ~clk;

  fifo_sync_ctrl #(
    .DW        (Dw),
    .AW        (Aw),
    .AF_THRESH (AfT),
    .AE_THRESH (AeT)
  ) dut (
    .I_CLK          (clk),
    .I_RSTN         (rst_n),
    .I_CLR          (clr),
    .I_WR_VALID     (wr_valid),
    .O_WR_READY     (wr_ready),
    .I_WR_DATA      (wr_data),
    .O_RD_VALID     (rd_valid),
    .I_RD_READY     (rd_ready),
    .O_RD_DATA      (rd_data),
    .O_COUNT        (count),
    .O_ALMOST_FULL  (almost_full),
    .O_ALMOST_EMPTY (almost_empty),
    .O_PEAK         (peak)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with the model's current occupancy.
  task automatic check_status(input string tag);
    int n;
    n = q.size();
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'(n < DepthM));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(n > 0));
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".af"}, 32'(almost_full), 32'(n >= AfT));
    check({tag, ".ae"}, 32'(almost_empty), 32'(n <= AeT));
    check({tag, ".peak"}, 32'(peak), 32'(peak_m));
    if (n > 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  // One clock cycle: apply inputs, check pre-edge status, advance model across the edge.
  task automatic step(input string tag, input logic wv, input logic [Dw-1:0] wd,
                      input logic rr, input logic cl, output logic wf);
    logic rf;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    clr      = cl;
    #1;
    check_status(tag);
    wf = wv && (q.size() < DepthM);
    rf = rr && (q.size() > 0);
    if (cl) begin
      q.delete();
      peak_m = 0;
    end else begin
      if (rf) void'(q.pop_front());
      if (wf) q.push_back(wd);
      if (q.size() > peak_m) peak_m = q.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'd1);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".peak"}, 32'(peak), 32'd0);
    check({tag, ".af"}, 32'(almost_full), 32'd0);
    check({tag, ".ae"}, 32'(almost_empty), 32'd1);
  endtask

  initial begin
    logic wf;
    logic [Dw-1:0] d;
    int tries;

    // Reset values.
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: two writes then two reads, FWFT latency of one cycle.
    step("s1w0", 1'b1, 8'hA1, 1'b0, 1'b0, wf);
    check("s1.rv_after_first", 32'(rd_valid), 32'd1);
    check("s1.head_a1", 32'(rd_data), 32'hA1);
    step("s1w1", 1'b1, 8'hA2, 1'b0, 1'b0, wf);
    step("s1r0", 1'b0, 8'h00, 1'b1, 1'b0, wf);
    check("s1.head_a2", 32'(rd_data), 32'hA2);
    step("s1r1", 1'b0, 8'h00, 1'b1, 1'b0, wf);
    step("s1idle", 1'b0, 8'h00, 1'b0, 1'b0, wf);

    // 2/3: overfill, then simultaneous read and write while full.
    for (int i = 0; i < 4; i++) step("s2w", 1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, wf);
    check("s2.count_full", 32'(count), 32'd4);
    check("s2.wr_ready_full", 32'(wr_ready), 32'd0);
    step("s2hold", 1'b1, 8'hB4, 1'b0, 1'b0, wf);
    check("s2.fifth_refused", 32'(wf), 32'd0);
    step("s3both", 1'b1, 8'hB4, 1'b1, 1'b0, wf);
    check("s3.write_refused", 32'(wf), 32'd0);
    check("s3.count_3", 32'(count), 32'd3);
    step("s3acc", 1'b1, 8'hB4, 1'b0, 1'b0, wf);
    check("s3.write_accepted", 32'(wf), 32'd1);
    check("s3.count_4", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) step("s2drain", 1'b0, 8'h00, 1'b1, 1'b0, wf);

    // 4: streaming across several pointer wraps.
    for (int i = 0; i < 16; i++) step("s4", 1'b1, 8'(i), 1'b1, 1'b0, wf);
    for (int i = 0; i < 3; i++) step("s4drain", 1'b0, 8'h00, 1'b1, 1'b0, wf);

    // 5: clear with a concurrent write drops everything.
    for (int i = 0; i < 3; i++) step("s5w", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, wf);
    step("s5clr", 1'b1, 8'hEE, 1'b0, 1'b1, wf);
    check("s5.count0", 32'(count), 32'd0);
    check("s5.peak0", 32'(peak), 32'd0);
    check("s5.rv0", 32'(rd_valid), 32'd0);
    step("s5after", 1'b1, 8'hD1, 1'b0, 1'b0, wf);
    step("s5rd", 1'b0, 8'h00, 1'b1, 1'b0, wf);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      step("rnd", 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0), wf);
    end

    // 6: asynchronous reset between edges during a burst.
    tries = 0;
    while (q.size() < 2 && tries < 16) begin
      step("s6fill", 1'b1, 8'h60 + 8'(tries), 1'b0, 1'b0, wf);
      tries++;
    end
    check("s6.primed", 32'(q.size() >= 2), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("s6async");
    q.delete();
    peak_m = 0;
    @(posedge clk);
    #1;
    check_reset_values("s6held");
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    step("s6idle", 1'b0, 8'h00, 1'b1, 1'b0, wf);
    step("s6w", 1'b1, 8'h5A, 1'b0, 1'b0, wf);
    step("s6r", 1'b0, 8'h00, 1'b1, 1'b0, wf);
    step("s6end", 1'b0, 8'h00, 1'b0, 1'b0, wf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
